// File: rtl/mio_arbiter_pkg.sv
// Shared types for the memory I/O arbiter.
//   state_t : controller states (encoding is visible on state_out)
//   owner_t : which requester owns the current transfer
//   xfer_t  : request payload captured at grant
package mio_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU_X = 2'd1,
    ST_DMA_X = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

endpackage

// File: rtl/mio_wait_timer.sv
// Wait-cycle counter for a memory transfer.
//   clk, rst : clock, synchronous active-low reset
//   clr      : restart the count (takes priority over en)
//   en       : count one more cycle without mem_ack
//   expired  : count has reached TIMEOUT-1
module mio_wait_timer
  import mio_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign expired = (count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mio_arbiter.sv
// Two-master (CPU, DMA) arbiter in front of a single memory port.
//   clk, rst            : clock, synchronous active-low reset
//   cpu_*               : CPU request; MIO_ready=0 stalls the CPU
//   dma_*               : DMA request; dma_ack pulses once per transfer
//   mem_*               : memory port; mem_ack completes the transfer
//   bus_err             : sticky timeout flag, cleared only by reset
//   state_out           : current controller state
module mio_arbiter
  import mio_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              MIO_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err,
  output logic [1:0]        state_out
);

  state_t state;
  owner_t owner;   // also serves as last_grant between transfers
  xfer_t  cap;

  logic in_x;
  logic grant_any;
  logic grant_cpu;
  logic expired;
  logic finish;

  assign in_x      = (state == ST_CPU_X) || (state == ST_DMA_X);
  assign grant_any = (state == ST_IDLE) && (cpu_req || dma_req);
  // On a tie, the requester that was not granted last wins.
  assign grant_cpu = cpu_req && (!dma_req || (owner == OWN_DMA));
  assign finish    = in_x && (mem_ack || expired);

  // Wait counter restarts on every grant and counts un-acked transfer cycles.
  mio_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_any),
    .en      (in_x && !mem_ack),
    .expired (expired)
  );

  // Memory port is decoded straight from the state and capture registers.
  assign mem_req   = in_x;
  assign mem_we    = in_x && cap.we;
  assign mem_addr  = cap.addr;
  assign mem_wdata = cap.wdata;
  assign state_out = 2'(state);

  // An idle CPU is never stalled; a requesting CPU is released in its DONE cycle.
  assign MIO_ready = !cpu_req || ((state == ST_DONE) && (owner == OWN_CPU));

  // Controller state, capture, read-data and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_DMA;
      cap       <= '0;
      dma_ack   <= 1'b0;
      bus_err   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      dma_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            if (grant_cpu) begin
              owner <= OWN_CPU;
              cap   <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
              state <= ST_CPU_X;
            end else begin
              owner <= OWN_DMA;
              cap   <= '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
              state <= ST_DMA_X;
            end
          end
        end
        ST_CPU_X, ST_DMA_X: begin
          if (finish) begin
            state   <= ST_DONE;
            dma_ack <= (owner == OWN_DMA);
            // Timeout returns zero data and latches the sticky error.
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
            if (owner == OWN_CPU) begin
              cpu_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dma_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Randomized scoreboard bench for mio_arbiter.
module tb_mio_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
  logic        MIO_ready, dma_ack, mem_req, mem_we, bus_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [1:0]  state_out;

  mio_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { bit to; int lat; logic [31:0] data; } plan_t;
  typedef struct { bit owner; txn_t t; int xc; logic [31:0] rdata; bit err; } exp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; bit stable; int xc; } obs_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  obs_t  obs_q[$];

  int checks = 0;
  int fails  = 0;

  // Reference model state: last served requester (1 = DMA), sticky error, held read data.
  bit          m_last = 1'b1;
  bit          m_err  = 1'b0;
  logic [31:0] m_cpu_rd = '0;
  logic [31:0] m_dma_rd = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int plan_xc(input plan_t p);
    return p.to ? int'(TIMEOUT) : p.lat + 1;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    t.addr = $urandom;
    t.wdata = $urandom;
    return t;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.to = ($urandom_range(0, 9) == 0);
    p.lat = int'($urandom_range(0, 3));
    p.data = $urandom;
    return p;
  endfunction

  task automatic push_exp(input bit owner, input txn_t t, input plan_t p);
    exp_t e;
    e.owner = owner;
    e.t = t;
    e.xc = plan_xc(p);
    e.rdata = p.to ? 32'h0 : p.data;
    e.err = m_err | p.to;
    m_err = e.err;
    exp_q.push_back(e);
    plan_q.push_back(p);
  endtask

  // Requester agents: hold the request until acknowledged, drop it the cycle after.
  task automatic cpu_agent(input txn_t t, input int exp_wait, input int scram);
    int n = 0;
    bit done = 1'b0;
    cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_req = 1'b1;
    while (!done && n < 300) begin
      @(posedge clk); #2;
      n++;
      if (cpu_req && MIO_ready) done = 1'b1;
      else if (n == scram) begin
        cpu_addr = t.addr ^ 32'h300; cpu_wdata = ~t.wdata; cpu_we = ~t.we;
      end
    end
    if (!done) check("cpu_ack_timeout", 32'(n), 32'(exp_wait));
    else if (exp_wait >= 0) check("cpu_latency", 32'(n), 32'(exp_wait));
    @(posedge clk); #2;
    cpu_req = 1'b0;
  endtask

  task automatic dma_agent(input txn_t t, input int exp_wait, input int scram);
    int n = 0;
    bit done = 1'b0;
    dma_we = t.we; dma_addr = t.addr; dma_wdata = t.wdata; dma_req = 1'b1;
    while (!done && n < 300) begin
      @(posedge clk); #2;
      n++;
      if (dma_ack) done = 1'b1;
      else if (n == scram) begin
        dma_addr = t.addr ^ 32'h300; dma_wdata = ~t.wdata; dma_we = ~t.we;
      end
    end
    if (!done) check("dma_ack_timeout", 32'(n), 32'(exp_wait));
    else if (exp_wait >= 0) check("dma_latency", 32'(n), 32'(exp_wait));
    @(posedge clk); #2;
    dma_req = 1'b0;
  endtask

  // One arbitration round: both requesters (optionally) assert in the same IDLE cycle.
  task automatic do_round(input bit ce, input bit de, input txn_t ct, input txn_t dt,
                          input plan_t cp, input plan_t dp, input int scram);
    bit cpu_first;
    bit solo;
    solo = !(ce && de);
    cpu_first = (ce && de) ? m_last : ce;
    if (cpu_first) begin
      if (ce) push_exp(1'b0, ct, cp);
      if (de) push_exp(1'b1, dt, dp);
    end else begin
      if (de) push_exp(1'b1, dt, dp);
      if (ce) push_exp(1'b0, ct, cp);
    end
    if (ce && de) m_last = cpu_first;
    else m_last = de;
    fork
      begin
        if (ce) cpu_agent(ct, solo ? plan_xc(cp) + 1 : -1, solo ? scram : 0);
      end
      begin
        if (de) dma_agent(dt, solo ? plan_xc(dp) + 1 : -1, solo ? scram : 0);
      end
    join
    @(posedge clk); #2;
  endtask

  // Memory model: follows the plan queue, records what it was asked to do.
  initial begin : memory
    bit    in_x;
    int    xc;
    plan_t cur;
    obs_t  ob;
    in_x = 1'b0;
    xc = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        if (!in_x) begin
          in_x = 1'b1;
          xc = 0;
          if (plan_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL mem_plan actual=empty expected=pending_plan");
            cur = '{to: 1'b1, lat: 0, data: 32'h0};
          end else begin
            cur = plan_q.pop_front();
          end
          ob = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, stable: 1'b1, xc: 0};
        end else if (mem_we !== ob.we || mem_addr !== ob.addr || mem_wdata !== ob.wdata) begin
          ob.stable = 1'b0;
        end
        xc++;
        if (!cur.to && xc == cur.lat + 1) begin
          mem_ack = 1'b1; mem_rdata = cur.data;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        if (in_x) begin
          in_x = 1'b0;
          ob.xc = xc;
          obs_q.push_back(ob);
        end
        // Stray acks outside a transfer must be ignored.
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every acknowledge pops one expected transfer.
  initial begin : monitor
    exp_t e;
    obs_t o;
    bit   got_cpu, got_dma;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        got_dma = (dma_ack === 1'b1);
        got_cpu = (cpu_req === 1'b1) && (MIO_ready === 1'b1);
        if (got_dma || got_cpu) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_ack actual=cpu%0b_dma%0b expected=none", got_cpu, got_dma);
          end else begin
            e = exp_q.pop_front();
            check("ack_owner_dma", 32'(got_dma), 32'(e.owner));
            check("ack_owner_cpu", 32'(got_cpu), 32'(!e.owner));
            check("done_state", 32'(state_out), 32'd3);
            check("bus_err", 32'(bus_err), 32'(e.err));
            if (e.owner) m_dma_rd = e.rdata;
            else m_cpu_rd = e.rdata;
            check("cpu_rdata", cpu_rdata, m_cpu_rd);
            check("dma_rdata", dma_rdata, m_dma_rd);
            if (obs_q.size() == 0) begin
              checks++; fails++;
              $display("FAIL mem_transfer actual=none expected=one");
            end else begin
              o = obs_q.pop_front();
              check("mem_addr", o.addr, e.t.addr);
              check("mem_we", 32'(o.we), 32'(e.t.we));
              check("mem_wdata", o.wdata, e.t.wdata);
              check("mem_stable", 32'(o.stable), 32'd1);
              check("x_cycles", 32'(o.xc), 32'(e.xc));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=hung expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    txn_t  ct, dt;
    plan_t cp, dp;
    int    sel;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_dma_ack", 32'(dma_ack), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
    check("rst_ready_idle", 32'(MIO_ready), 32'd1);
    cpu_req = 1'b1; #1;
    check("rst_ready_req", 32'(MIO_ready), 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // First tie after reset: CPU served first.
    do_round(1'b1, 1'b1, rand_txn(), rand_txn(),
             '{to: 1'b0, lat: 0, data: $urandom}, '{to: 1'b0, lat: 1, data: $urandom}, 0);

    // CPU-only read of 0x10 acked in the first transfer cycle.
    ct = '{we: 1'b0, addr: 32'h0000_0010, wdata: $urandom};
    cp = '{to: 1'b0, lat: 0, data: 32'h1234_5678};
    do_round(1'b1, 1'b0, ct, rand_txn(), cp, rand_plan(), 1);
    check("cpu_read_data", cpu_rdata, 32'h1234_5678);

    // Tie after a CPU grant: DMA served first.
    do_round(1'b1, 1'b1, rand_txn(), rand_txn(),
             '{to: 1'b0, lat: 2, data: $urandom}, '{to: 1'b0, lat: 0, data: $urandom}, 0);

    // DMA write with the address input changed mid-transfer.
    dt = '{we: 1'b1, addr: 32'h0000_0100, wdata: 32'hCAFE_F00D};
    dp = '{to: 1'b0, lat: 3, data: $urandom};
    do_round(1'b0, 1'b1, rand_txn(), dt, rand_plan(), dp, 2);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      do_round(sel != 1, sel != 0, rand_txn(), rand_txn(), rand_plan(), rand_plan(), 1);
    end

    // Forced timeout, then good transfers keep bus_err set.
    do_round(1'b1, 1'b0, rand_txn(), rand_txn(), '{to: 1'b1, lat: 0, data: $urandom}, rand_plan(), 1);
    check("timeout_cpu_rdata", cpu_rdata, 32'h0);
    do_round(1'b0, 1'b1, rand_txn(), rand_txn(), rand_plan(), '{to: 1'b0, lat: 1, data: $urandom}, 1);
    do_round(1'b1, 1'b0, rand_txn(), rand_txn(), '{to: 1'b0, lat: 0, data: $urandom}, rand_plan(), 1);
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the second DMA transfer cycle aborts silently.
    plan_q.push_back('{to: 1'b0, lat: 3, data: $urandom});
    dt = rand_txn();
    dma_we = dt.we; dma_addr = dt.addr; dma_wdata = dt.wdata; dma_req = 1'b1;
    @(posedge clk); #2;
    check("abort_x1_state", 32'(state_out), 32'd2);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_dma_ack", 32'(dma_ack), 32'd0);
    check("abort_bus_err", 32'(bus_err), 32'd0);
    check("abort_dma_rdata", dma_rdata, 32'd0);
    dma_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    check("abort_no_ack", 32'(dma_ack), 32'd0);
    obs_q.delete();
    m_last = 1'b1; m_err = 1'b0; m_cpu_rd = '0; m_dma_rd = '0;
    do_round(1'b1, 1'b1, rand_txn(), rand_txn(), rand_plan(), rand_plan(), 0);

    repeat (3) @(posedge clk);
    #2;
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("plan_drained", 32'(plan_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
